// File: rtl/fir_serial_mac.sv
// Time-multiplexed FIR filter: one multiply-accumulate unit walks a circular sample
// history against runtime-loadable coefficients, then rounds and saturates the sum.
module fir_serial_mac #(
  parameter  int TAPS   = 401,
  parameter  int DATA_W = 16,
  parameter  int COEF_W = 16,
  parameter  int OUT_W  = 16,
  parameter  int SHIFT  = 15,
  localparam int AW     = $clog2(TAPS),
  localparam int ACC_W  = DATA_W + COEF_W + AW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_sample,
  input  logic              coef_wr_en,
  input  logic [AW-1:0]     coef_wr_addr,
  input  logic [COEF_W-1:0] coef_wr_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [OUT_W-1:0]  out_sample,
  output logic              out_sat
);

  localparam int PW = DATA_W + COEF_W;
  localparam logic [AW:0] TAPS_W = (AW+1)'(TAPS);
  localparam logic [AW-1:0] LAST = AW'(TAPS - 1);
  localparam int RS = (SHIFT > 0) ? SHIFT - 1 : 0;
  localparam logic signed [ACC_W:0] RND = (SHIFT > 0) ? ((ACC_W+1)'(1) << RS) : '0;
  localparam logic signed [ACC_W:0] OMAX = {{(ACC_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W:0] OMIN = {{(ACC_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  state_t state, state_nxt;

  logic signed [DATA_W-1:0] hist [TAPS];
  logic signed [COEF_W-1:0] coef [TAPS];

  logic [AW-1:0]            wptr, base, rd_k, rd_idx;
  logic [AW:0]              fill, k, wrap_idx;
  logic signed [DATA_W-1:0] x_q;
  logic signed [COEF_W-1:0] h_q;
  logic                     m_q, rd_v;
  logic signed [PW-1:0]     x_ext, h_ext, mult, prod;
  logic signed [ACC_W-1:0]  acc, acc_sum;
  logic signed [ACC_W:0]    rnd_sum, shifted;
  logic [OUT_W-1:0]         sat_out;
  logic                     sat_hi, sat_lo, accept;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // MAC issues TAPS reads plus one cycle to flush the read/product pipeline.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept) state_nxt = MAC;
      MAC:     if (k == TAPS_W) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      OUT:     if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE) && !rst;
    out_valid = (state == OUT);
  end

  assign accept = in_valid && in_ready;

  // Tap k pairs coef[k] with the sample k steps older than the newest one.
  always_comb begin
    rd_k     = (k < TAPS_W) ? k[AW-1:0] : '0;
    wrap_idx = {1'b0, base} + TAPS_W - {1'b0, rd_k};
    rd_idx   = (base >= rd_k) ? base - rd_k : wrap_idx[AW-1:0];
  end

  // Memories and their read registers carry no reset, like a synchronous RAM.
  always_ff @(posedge clk) begin
    if (accept) hist[wptr] <= in_sample;
    if (coef_wr_en && (state == IDLE) && ({1'b0, coef_wr_addr} < TAPS_W))
      coef[coef_wr_addr] <= coef_wr_data;
    x_q <= hist[rd_idx];
    h_q <= coef[rd_k];
    m_q <= (k < fill);
  end

  always_comb begin
    x_ext   = {{COEF_W{x_q[DATA_W-1]}}, x_q};
    h_ext   = {{DATA_W{h_q[COEF_W-1]}}, h_q};
    mult    = x_ext * h_ext;
    acc_sum = acc + {{AW{prod[PW-1]}}, prod};
    rnd_sum = {acc_sum[ACC_W-1], acc_sum} + RND;
    shifted = rnd_sum >>> SHIFT;
    sat_hi  = shifted > OMAX;
    sat_lo  = shifted < OMIN;
    if (sat_hi)      sat_out = OMAX[OUT_W-1:0];
    else if (sat_lo) sat_out = OMIN[OUT_W-1:0];
    else             sat_out = shifted[OUT_W-1:0];
  end

  // Taps beyond the fill count contribute zero so stale history never leaks in.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr       <= '0;
      base       <= '0;
      fill       <= '0;
      k          <= '0;
      rd_v       <= 1'b0;
      prod       <= '0;
      acc        <= '0;
      out_sample <= '0;
      out_sat    <= 1'b0;
    end else begin
      rd_v <= (state == MAC) && (k < TAPS_W);
      prod <= (rd_v && m_q) ? mult : '0;
      unique case (state)
        IDLE: begin
          if (accept) begin
            base <= wptr;
            wptr <= (wptr == LAST) ? '0 : wptr + 1'b1;
            if (fill < TAPS_W) fill <= fill + 1'b1;
            acc  <= '0;
            k    <= '0;
          end
        end
        MAC: begin
          acc <= acc_sum;
          k   <= k + 1'b1;
        end
        DRAIN: begin
          acc        <= acc_sum;
          out_sample <= sat_out;
          out_sat    <= sat_hi || sat_lo;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_serial_mac.sv
// Bench for fir_serial_mac: instances with SHIFT=0 and SHIFT=1 share stimulus and are
// checked against a convolution model built from a queue of accepted samples.
module tb_fir_serial_mac;

  localparam int TAPS = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, out_ready, coef_wr_en;
  logic [15:0] in_sample, coef_wr_data;
  logic [1:0]  coef_wr_addr;
  logic        in_ready0, in_ready1, out_valid0, out_valid1, out_sat0, out_sat1;
  logic [15:0] out_sample0, out_sample1;

  int     checks = 0;
  int     errors = 0;
  longint hist_q[$];
  longint coef_m[TAPS];

  always #5 clk = ~clk;

  fir_serial_mac #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(0)) dut0 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready0), .in_sample(in_sample),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .out_valid(out_valid0), .out_ready(out_ready), .out_sample(out_sample0), .out_sat(out_sat0)
  );

  fir_serial_mac #(.TAPS(TAPS), .DATA_W(16), .COEF_W(16), .OUT_W(16), .SHIFT(1)) dut1 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready1), .in_sample(in_sample),
    .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr), .coef_wr_data(coef_wr_data),
    .out_valid(out_valid1), .out_ready(out_ready), .out_sample(out_sample1), .out_sat(out_sat1)
  );

  task automatic checkOutput(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint convolve();
    longint s = 0;
    for (int i = 0; i < hist_q.size(); i++) s += hist_q[i] * coef_m[i];
    return s;
  endfunction

  function automatic void expOut(input longint acc, input int sh, output longint y, output longint sat);
    longint r;
    r = (sh > 0) ? ((acc + (longint'(1) <<< (sh - 1))) >>> sh) : acc;
    sat = 1;
    if (r > 32767) y = 32767;
    else if (r < -32768) y = -32768;
    else begin
      y   = r;
      sat = 0;
    end
  endfunction

  function automatic int randS16();
    shortint v;
    if ($urandom_range(0, 1) == 1) return int'($urandom_range(0, 200)) - 100;
    v = shortint'($urandom);
    return int'(v);
  endfunction

  task automatic writeCoef(input int idx, input int val);
    coef_wr_en   = 1'b1;
    coef_wr_addr = 2'(idx);
    coef_wr_data = 16'(val);
    @(negedge clk);
    coef_wr_en = 1'b0;
    coef_m[idx] = val;
  endtask

  task automatic doReset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready0", in_ready0, 0);
    checkOutput("rst_in_ready1", in_ready1, 0);
    checkOutput("rst_out_valid", out_valid0 | out_valid1, 0);
    checkOutput("rst_out_sample", longint'(out_sample0) + longint'(out_sample1), 0);
    checkOutput("rst_out_sat", out_sat0 | out_sat1, 0);
    rst = 1'b0;
    @(negedge clk);
    checkOutput("post_rst_in_ready", in_ready0 & in_ready1, 1);
    hist_q.delete();
  endtask

  // wrMode: 0 no write, 1 coefficient write on the accept cycle, 2 write pulsed while busy
  task automatic applyStimulus(input int s, input int hold, input int wrMode,
                               input int wrAddr, input int wrData);
    int     n;
    longint raw, y0, y1, s0, s1;
    n = 0;
    while (!in_ready0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready_idle", in_ready0, 1);
    in_valid  = 1'b1;
    in_sample = 16'(s);
    if (wrMode == 1) begin
      coef_wr_en     = 1'b1;
      coef_wr_addr   = 2'(wrAddr);
      coef_wr_data   = 16'(wrData);
      coef_m[wrAddr] = wrData;
    end
    @(negedge clk);
    in_valid   = 1'b0;
    coef_wr_en = 1'b0;
    hist_q.push_front(longint'(s));
    if (hist_q.size() > TAPS) void'(hist_q.pop_back());
    raw = convolve();
    expOut(raw, 0, y0, s0);
    expOut(raw, 1, y1, s1);
    n = 0;
    if (wrMode == 2) begin
      coef_wr_en   = 1'b1;
      coef_wr_addr = 2'(wrAddr);
      coef_wr_data = 16'(wrData);
      @(negedge clk);
      n++;
      coef_wr_en = 1'b0;
    end
    while (!out_valid0 && n < TAPS + 10) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency", n, TAPS + 2);
    checkOutput("busy_in_ready", in_ready0 | in_ready1, 0);
    checkOutput("sample0", longint'($signed(out_sample0)), y0);
    checkOutput("sat0", out_sat0, s0);
    if (hold > 0) begin
      repeat (hold) @(negedge clk);
      checkOutput("hold_valid", out_valid0 & out_valid1, 1);
      checkOutput("hold_in_ready", in_ready0, 0);
      checkOutput("hold_sample0", longint'($signed(out_sample0)), y0);
      checkOutput("hold_sat0", out_sat0, s0);
    end
    checkOutput("sample1", longint'($signed(out_sample1)), y1);
    checkOutput("sat1", out_sat1, s1);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    checkOutput("valid_drop", out_valid0 | out_valid1, 0);
  endtask

  initial begin
    rst          = 1'b1;
    in_valid     = 1'b0;
    in_sample    = '0;
    out_ready    = 1'b0;
    coef_wr_en   = 1'b0;
    coef_wr_addr = '0;
    coef_wr_data = '0;
    doReset();

    $display("[TB] impulse response");
    writeCoef(0, 10); writeCoef(1, 20); writeCoef(2, 30); writeCoef(3, 40);
    applyStimulus(1, 0, 0, 0, 0);
    repeat (4) applyStimulus(0, 0, 0, 0, 0);

    $display("[TB] fill after reset");
    doReset();
    applyStimulus(5, 0, 0, 0, 0);
    applyStimulus(5, 0, 0, 0, 0);

    $display("[TB] saturation");
    for (int i = 0; i < TAPS; i++) writeCoef(i, 32767);
    repeat (2) applyStimulus(32767, 0, 0, 0, 0);
    repeat (4) applyStimulus(-32768, 0, 0, 0, 0);

    $display("[TB] rounding");
    writeCoef(0, 1); writeCoef(1, 0); writeCoef(2, 0); writeCoef(3, 0);
    doReset();
    applyStimulus(3, 0, 0, 0, 0);
    applyStimulus(-3, 0, 0, 0, 0);
    applyStimulus(-4, 0, 0, 0, 0);

    $display("[TB] backpressure and coefficient writes");
    applyStimulus(100, 10, 2, 0, 99);
    applyStimulus(50, 0, 0, 0, 0);
    applyStimulus(9, 1, 1, 1, 2);

    $display("[TB] reset during MAC");
    writeCoef(0, 10);
    in_valid  = 1'b1;
    in_sample = 16'd123;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    doReset();
    applyStimulus(7, 0, 0, 0, 0);

    $display("[TB] randomized traffic");
    for (int t = 0; t < 24; t++) begin
      if (t % 6 == 0)
        for (int i = 0; i < TAPS; i++) writeCoef(i, randS16());
      applyStimulus(randS16(), $urandom_range(0, 3), $urandom_range(0, 2),
                    $urandom_range(0, TAPS - 1), randS16());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
